retire_tracer: RTL

Downstream consumer of the hart's retire interface. Captures every retired instruction into a small buffer and presents it as a ready/valid trace stream to a testbench or debug port. Also keeps cycle/instret counters and sticky trap/overflow status, and runs a halt-drain sequence that asserts `o_done` once the final `ebreak` record has been consumed.

---
 rtl/retire_tracer_pkg.sv | 19 +
 rtl/trace_fifo.sv | 52 +++++
 rtl/retire_tracer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/retire_tracer_pkg.sv
// Shared types for the retire tracer: the captured trace record and the
// halt-drain state machine encoding.
package retire_tracer_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] next_pc;
      logic [31:0] inst;
      logic [31:0] rd_wdata;
      logic [4:0]  rd_waddr;
      logic        trap;
      logic        halt;
   } trace_rec_t;

   localparam int TRACE_REC_W = $bits(trace_rec_t);

   typedef enum logic [1:0] {RUN, DRAIN, DONE} tracer_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace records; the head is read straight from storage
// flops, so there is no path from the write port to the head.
module trace_fifo
   import retire_tracer_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  trace_rec_t               i_rec,
   input  logic                     i_pop,
   output trace_rec_t               o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;
   trace_rec_t  r_mem [DEPTH];

   logic w_wr;
   logic w_rd;

   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
   assign o_count = r_wptr - r_rptr;
   assign o_head  = r_mem[r_rptr[AW-1:0]];

   assign w_rd = i_pop & ~o_empty;
   // When full, a same-cycle pop frees the head slot, which is the write slot.
   assign w_wr = i_push & (~o_full | w_rd);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= i_rec;
            r_wptr                <= r_wptr + PTR_ONE;
         end
         if (w_rd) r_rptr <= r_rptr + PTR_ONE;
      end
   end

endmodule

// File: rtl/retire_tracer.sv
// Retire-interface tracer: buffers retirements into a trace stream, keeps
// cycle/instret/drop counters and sticky flags, and drains after a halt.
module retire_tracer
   import retire_tracer_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DROP_W = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_retire_valid,
   input  logic [31:0]       i_retire_pc,
   input  logic [31:0]       i_retire_next_pc,
   input  logic [31:0]       i_retire_inst,
   input  logic [31:0]       i_retire_rd_wdata,
   input  logic [4:0]        i_retire_rd_waddr,
   input  logic              i_retire_trap,
   input  logic              i_retire_halt,
   output logic              o_trace_valid,
   input  logic              i_trace_ready,
   output logic [31:0]       o_trace_pc,
   output logic [31:0]       o_trace_next_pc,
   output logic [31:0]       o_trace_inst,
   output logic [31:0]       o_trace_rd_wdata,
   output logic [4:0]        o_trace_rd_waddr,
   output logic              o_trace_trap,
   output logic              o_trace_halt,
   output logic [63:0]       o_cycle,
   output logic [63:0]       o_instret,
   output logic [DROP_W-1:0] o_drop_count,
   output logic              o_overflow,
   output logic              o_trap_seen,
   output logic              o_done
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

   tracer_state_t     r_state;
   tracer_state_t     w_state_nxt;
   logic [63:0]       r_cycle;
   logic [63:0]       r_instret;
   logic [DROP_W-1:0] r_drop;
   logic              r_overflow;
   logic              r_trap_seen;

   trace_rec_t  w_rec;
   trace_rec_t  w_head;
   logic        w_full;
   logic        w_empty;
   logic [AW:0] w_count;
   logic        w_attempt;
   logic        w_pop;
   logic        w_drop;

   assign w_rec = '{pc: i_retire_pc, next_pc: i_retire_next_pc, inst: i_retire_inst,
                    rd_wdata: i_retire_rd_wdata, rd_waddr: i_retire_rd_waddr,
                    trap: i_retire_trap, halt: i_retire_halt};

   assign w_attempt = i_retire_valid & (r_state == RUN);
   assign w_pop     = ~w_empty & i_trace_ready;
   assign w_drop    = w_attempt & w_full & ~w_pop;

   trace_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_attempt),
      .i_rec   (w_rec),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= RUN;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN:   if (w_attempt && i_retire_halt) w_state_nxt = DRAIN;
         // Either already empty, or the last queued record leaves this cycle.
         DRAIN: if (w_empty || (w_pop && w_count == CNT_ONE)) w_state_nxt = DONE;
         default: w_state_nxt = r_state;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cycle     <= '0;
         r_instret   <= '0;
         r_drop      <= '0;
         r_overflow  <= 1'b0;
         r_trap_seen <= 1'b0;
      end else begin
         if (r_state != DONE) r_cycle <= r_cycle + 64'd1;
         if (w_attempt) begin
            r_instret <= r_instret + 64'd1;
            if (i_retire_trap) r_trap_seen <= 1'b1;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop != '1) r_drop <= r_drop + DROP_W'(1);
         end
      end
   end

   assign o_trace_valid    = ~w_empty;
   assign o_trace_pc       = w_head.pc;
   assign o_trace_next_pc  = w_head.next_pc;
   assign o_trace_inst     = w_head.inst;
   assign o_trace_rd_wdata = w_head.rd_wdata;
   assign o_trace_rd_waddr = w_head.rd_waddr;
   assign o_trace_trap     = w_head.trap;
   assign o_trace_halt     = w_head.halt;
   assign o_cycle          = r_cycle;
   assign o_instret        = r_instret;
   assign o_drop_count     = r_drop;
   assign o_overflow       = r_overflow;
   assign o_trap_seen      = r_trap_seen;
   assign o_done           = (r_state == DONE);

endmodule
